uart_score_loader: RTL

Frame parser between `uart_recv` and the note-sequencing FSM of the music player. It accepts a framed score over UART, checks it, and writes note/duration records into an internal score RAM. The sequencer reads that RAM through a synchronous read port. The block returns an ACK or NAK byte through `uart_send`, replacing the single-byte `music_note` path.

---
 rtl/uart_score_loader.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_score_loader.sv
// Framed score loader: parses A5/N/records/CHK from uart_recv into a score RAM and answers ACK/NAK.
// Optional inter-byte timeout is compiled in when LOADER_TIMEOUT_EN is defined.
module uart_score_loader #(
    parameter int unsigned DEPTH       = 128,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned NOTE_W      = 5,
    parameter int unsigned TIME_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 12_000_000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              rx_done,
    input  logic [7:0]        rx_data,
    input  logic              tx_busy,
    output logic              tx_en,
    output logic [7:0]        tx_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [NOTE_W-1:0] rd_note,
    output logic [TIME_W-1:0] rd_time,
    output logic [7:0]        score_len,
    output logic              score_valid,
    output logic              load_busy,
    output logic [2:0]        err_code
);
    localparam int unsigned IDX_W = ADDR_W + 1;
    localparam int unsigned REC_W = NOTE_W + TIME_W;
    localparam logic [7:0]  SOF   = 8'hA5;
    localparam logic [7:0]  ACK   = 8'h06;
    localparam logic [7:0]  NAK   = 8'h15;

    if (DEPTH < 1 || DEPTH > 255 || (1 << ADDR_W) < DEPTH || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("uart_score_loader: illegal parameter set");
    end

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_NOTE, S_THI, S_TLO, S_CHK, S_RESP} state_t;

    state_t              state_q, state_d;
    logic                rx_done_q;
    logic                byte_acc;
    logic [7:0]          len_q, len_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic [7:0]          thi_q, thi_d;
    logic [7:0]          xor_q, xor_d;
    logic                tx_en_d;
    logic [7:0]          tx_data_d;
    logic [7:0]          score_len_d;
    logic                score_valid_d;
    logic [2:0]          err_d;
    logic                we_c;
    logic [REC_W-1:0]    mem [DEPTH];

    assign byte_acc = rx_done & ~rx_done_q;

`ifdef LOADER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;
    logic            timeout_c;

    // Counts idle cycles between accepted bytes while a frame is open.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            to_cnt <= '0;
        end else if (byte_acc || state_q == S_IDLE || state_q == S_RESP) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign timeout_c = (state_q inside {S_LEN, S_NOTE, S_THI, S_TLO, S_CHK}) &&
                       (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        idx_d         = idx_q;
        note_d        = note_q;
        thi_d         = thi_q;
        xor_d         = xor_q;
        tx_en_d       = 1'b0;
        tx_data_d     = tx_data;
        score_len_d   = score_len;
        score_valid_d = score_valid;
        err_d         = err_code;
        we_c          = 1'b0;
        case (state_q)
            S_IDLE: if (byte_acc && rx_data == SOF) begin
                state_d       = S_LEN;
                score_valid_d = 1'b0;
                err_d         = 3'd0;
                xor_d         = 8'h00;
                idx_d         = '0;
            end
            S_LEN: if (byte_acc) begin
                if (rx_data == 8'h00 || 32'(rx_data) > DEPTH) begin
                    state_d   = S_RESP;
                    tx_data_d = NAK;
                    err_d     = 3'd1;
                end else begin
                    len_d   = rx_data;
                    xor_d   = xor_q ^ rx_data;
                    state_d = S_NOTE;
                end
            end
            S_NOTE: if (byte_acc) begin
                xor_d = xor_q ^ rx_data;
                if (32'(rx_data) >= (32'd1 << NOTE_W)) begin
                    state_d   = S_RESP;
                    tx_data_d = NAK;
                    err_d     = 3'd2;
                end else begin
                    note_d  = NOTE_W'(rx_data);
                    state_d = S_THI;
                end
            end
            S_THI: if (byte_acc) begin
                xor_d   = xor_q ^ rx_data;
                thi_d   = rx_data;
                state_d = S_TLO;
            end
            S_TLO: if (byte_acc) begin
                xor_d   = xor_q ^ rx_data;
                we_c    = 1'b1;
                idx_d   = idx_q + IDX_W'(1);
                state_d = (32'(idx_q) + 32'd1 == 32'(len_q)) ? S_CHK : S_NOTE;
            end
            S_CHK: if (byte_acc) begin
                xor_d   = xor_q ^ rx_data;
                state_d = S_RESP;
                if (rx_data == xor_q) begin
                    score_len_d   = len_q;
                    score_valid_d = 1'b1;
                    tx_data_d     = ACK;
                end else begin
                    tx_data_d = NAK;
                    err_d     = 3'd3;
                end
            end
            S_RESP: if (!tx_busy) begin
                tx_en_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef LOADER_TIMEOUT_EN
        // A byte accepted on the expiring edge takes priority.
        if (timeout_c && !byte_acc) begin
            state_d   = S_RESP;
            tx_data_d = NAK;
            err_d     = 3'd4;
        end
`endif
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_done_q   <= 1'b0;
            len_q       <= 8'h00;
            idx_q       <= '0;
            note_q      <= '0;
            thi_q       <= 8'h00;
            xor_q       <= 8'h00;
            tx_en       <= 1'b0;
            tx_data     <= 8'h00;
            score_len   <= 8'h00;
            score_valid <= 1'b0;
            err_code    <= 3'd0;
            load_busy   <= 1'b0;
        end else begin
            rx_done_q   <= rx_done;
            len_q       <= len_d;
            idx_q       <= idx_d;
            note_q      <= note_d;
            thi_q       <= thi_d;
            xor_q       <= xor_d;
            tx_en       <= tx_en_d;
            tx_data     <= tx_data_d;
            score_len   <= score_len_d;
            score_valid <= score_valid_d;
            err_code    <= err_d;
            load_busy   <= (state_d != S_IDLE);
        end
    end

    // Score RAM: written in place, contents survive reset.
    always_ff @(posedge sys_clk) begin
        if (we_c) mem[idx_q[ADDR_W-1:0]] <= REC_W'({note_q, TIME_W'({thi_q, rx_data})});
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_note <= '0;
            rd_time <= '0;
        end else begin
            {rd_note, rd_time} <= mem[rd_addr];
        end
    end

endmodule
